seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits; legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit stays selected; must be at least 2.
REQ-003 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period; must be at least 2.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1: single clock.
- rst  in  1: asynchronous, active-high reset.
- en  in  1: display enable.
- value  in  4*NUM_DIGITS: digit nibbles; digit 0 is bits [3:0] and is the least significant digit.
- dec_mode  in  1: 1 = decimal mode, codes 10..15 blank; 0 = hex glyphs A,b,C,d,E,F.
- lz_suppress  in  1: leading-zero blanking enable.
- blink_mask  in  NUM_DIGITS: per-digit blink enable.
- dp  in  NUM_DIGITS: per-digit decimal point request, 1 = lit.
- seg  out  7: active-low segments, bit order g..a.
- seg_dp  out  1: active-low decimal point.
- an  out  NUM_DIGITS: active-low, one-hot digit select.
- digit_idx  out  clog2(NUM_DIGITS): index of the currently driven digit.

Function
REQ-005 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on its terminal count, digit_idx SHALL advance by one and wrap from NUM_DIGITS-1 to 0.
REQ-006 When digit_idx wraps to 0 (frame boundary), value, dp, blink_mask, dec_mode and lz_suppress SHALL be captured into shadow registers; all digit decoding SHALL use the shadow copies only, so no frame tears.
REQ-007 The blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on terminal count; blink_phase 1 = hidden.
REQ-008 seg, seg_dp and an SHALL be registered and SHALL reflect the digit selected by digit_idx exactly one cycle after digit_idx changes.
REQ-009 Glyphs (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
REQ-010 Leading-zero suppression: with shadow lz_suppress=1, every zero digit above the most significant nonzero digit SHALL be blank, and digit 0 SHALL always be shown. Blanked digits still honour dp.
REQ-011 A digit whose shadow blink_mask bit is 1 SHALL be driven blank, with dp off, while blink_phase=1.
REQ-012 When en=0, the an, seg and seg_dp outputs SHALL all be driven to all ones on the next cycle; the scan and blink counters SHALL keep running.
REQ-013 When en returns to 1, the outputs SHALL show the current digit_idx on the next cycle, with no resynchronisation wait.
REQ-014 If the scan and blink terminal counts coincide, both SHALL take effect in the same cycle; the output register SHALL use the new blink_phase one cycle later.

Reset
REQ-015 While rst=1, the following SHALL hold asynchronously: scan counter 0, digit_idx 0, blink counter 0, blink_phase 0, all shadow registers 0, an all ones, seg 1111111, seg_dp 1.
REQ-016 After rst deasserts, the first shadow capture SHALL occur on the first clock edge, because digit_idx is already 0 there; the display SHALL be valid from the second edge.
REQ-017 Asserting rst mid-frame SHALL abandon that frame with no further output update until release.

Structure
REQ-018 Package seg_pkg SHALL hold the 16 glyph constants, SEG_BLANK, and the bit-order definition of seg.
REQ-019 Combinational sub-module seg_glyph_decode SHALL map (nibble, dec_mode) to the 7-bit glyph. The scan driver SHALL instantiate it once, on the muxed digit.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=32)
REQ-020 Scan test: after reset with en=1, digit_idx steps 0,1,2,3,0 every 4 cycles; an walks 1110, 1101, 1011, 0111.
REQ-021 Decode test: value=0x12AF, dec_mode=0 -> digits 0..3 show F, A, 2, 1. With dec_mode=1 -> digits 0 and 1 show blank.
REQ-022 Zero-suppression test: value=0x0050, lz_suppress=1 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. value=0x0000 -> only digit 0 shows 0.
REQ-023 Tear test: change value from 0x1111 to 0x2222 while digit_idx=2 -> digits 2 and 3 still show 1 in that frame; the next frame shows 2 on all digits.
REQ-024 Blink and enable test: blink_mask=0001 -> digit 0 blank for cycles 32..63 and lit for 64..95. en=0 for 10 cycles -> an=1111 one cycle later; re-enabling mid-digit gives valid output one cycle later.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment bit order, active-low glyph constants and the blank pattern.
package seg_pkg;

    // seg[6] is segment g, seg[0] is segment a; all segments active-low
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_bits_t;

    localparam int unsigned SEG_W = $bits(seg_bits_t);

    localparam logic [SEG_W-1:0] GLYPH_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_A   = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B   = 7'b0000011;
    localparam logic [SEG_W-1:0] GLYPH_C   = 7'b1000110;
    localparam logic [SEG_W-1:0] GLYPH_D   = 7'b0100001;
    localparam logic [SEG_W-1:0] GLYPH_E   = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_F   = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational nibble-to-glyph decoder; in decimal mode codes 10..15 blank.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dec_mode,
    output logic [SEG_W-1:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = dec_mode ? SEG_BLANK : GLYPH_A;
            4'hB:    glyph = dec_mode ? SEG_BLANK : GLYPH_B;
            4'hC:    glyph = dec_mode ? SEG_BLANK : GLYPH_C;
            4'hD:    glyph = dec_mode ? SEG_BLANK : GLYPH_D;
            4'hE:    glyph = dec_mode ? SEG_BLANK : GLYPH_E;
            default: glyph = dec_mode ? SEG_BLANK : GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: digit scan, frame-locked shadow inputs,
// leading-zero blanking, per-digit blink and registered active-low outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          dec_mode,
    input  logic                          lz_suppress,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic [NUM_DIGITS-1:0]         dp,
    output logic [SEG_W-1:0]              seg,
    output logic                          seg_dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    localparam logic [IDX_W-1:0]   LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]       scan_cnt;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic                    scan_tc;
    logic                    blink_tc;
    logic                    frame_start;
    logic                    fresh;

    logic [4*NUM_DIGITS-1:0] val_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blink_sh;
    logic                    dec_sh;
    logic                    lz_sh;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    seen_nz;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic                    hide;
    logic [SEG_W-1:0]        glyph;

    assign scan_tc  = (scan_cnt == SCAN_LAST);
    assign blink_tc = (blink_cnt == BLINK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            if (scan_tc) begin
                digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
            if (blink_tc) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    // Capture on the edge that wraps digit_idx to 0, so digit 0 is decoded from
    // the new frame on its first output cycle; 'fresh' covers the first edge
    // after reset, where digit_idx is already 0 without a wrap.
    assign frame_start = fresh || (scan_tc && (digit_idx == LAST_DIGIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fresh    <= 1'b1;
            val_sh   <= '0;
            dp_sh    <= '0;
            blink_sh <= '0;
            dec_sh   <= 1'b0;
            lz_sh    <= 1'b0;
        end else begin
            fresh <= 1'b0;
            if (frame_start) begin
                val_sh   <= value;
                dp_sh    <= dp;
                blink_sh <= blink_mask;
                dec_sh   <= dec_mode;
                lz_sh    <= lz_suppress;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            if (val_sh[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lz_blank[i] = lz_sh && !seen_nz;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = val_sh[4*i +: 4];
                cur_dp    = dp_sh[i];
                cur_blink = blink_sh[i];
                cur_lz    = lz_blank[i];
            end
        end
    end

    assign hide = blink_phase && cur_blink;

    seg_glyph_decode u_decode (
        .nibble   (cur_nib),
        .dec_mode (dec_sh),
        .glyph    (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an     <= '1;
            seg    <= SEG_BLANK;
            seg_dp <= 1'b1;
        end else if (!en) begin
            an     <= '1;
            seg    <= '1;
            seg_dp <= 1'b1;
        end else begin
            an     <= ~(NUM_DIGITS'(1) << digit_idx);
            seg    <= (hide || cur_lz) ? SEG_BLANK : glyph;
            seg_dp <= ~(cur_dp && !hide);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against an edge-count
// based reference model of scan position, blink phase and frame snapshots.
module tb_seg_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BD = 32;

    logic            clk;
    logic            rst;
    logic            en;
    logic [4*ND-1:0] value;
    logic            dec_mode;
    logic            lz_suppress;
    logic [ND-1:0]   blink_mask;
    logic [ND-1:0]   dp;
    logic [6:0]      seg;
    logic            seg_dp;
    logic [ND-1:0]   an;
    logic [1:0]      digit_idx;

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .value       (value),
        .dec_mode    (dec_mode),
        .lz_suppress (lz_suppress),
        .blink_mask  (blink_mask),
        .dp          (dp),
        .seg         (seg),
        .seg_dp      (seg_dp),
        .an          (an),
        .digit_idx   (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] gtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model state: edges since reset release plus the latest frame snapshot.
    int unsigned ecnt;
    logic [15:0] s_val;
    logic [3:0]  s_dp;
    logic [3:0]  s_blink;
    logic        s_dec;
    logic        s_lz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, ecnt, $time);
        end
    endtask

    task automatic model_clear();
        ecnt    = 0;
        s_val   = '0;
        s_dp    = '0;
        s_blink = '0;
        s_dec   = 1'b0;
        s_lz    = 1'b0;
    endtask

    task automatic step();
        int unsigned idx;
        int unsigned ph;
        logic [3:0]  nib;
        logic        hide;
        logic        lzb;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;

        idx  = (ecnt / SD) % ND;
        ph   = (ecnt / BD) % 2;
        nib  = s_val[4*idx +: 4];
        hide = (ph == 1) && s_blink[idx];
        lzb  = s_lz && (idx != 0) && ((s_val >> (4*idx)) == 16'd0);
        if (!en) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an  = ~(4'b0001 << idx);
            e_seg = (hide || lzb || (s_dec && nib > 4'd9)) ? 7'h7F : gtab[nib];
            e_dp  = hide ? 1'b1 : ~s_dp[idx];
        end
        // Snapshot happens on edge 1 after reset and on every frame wrap edge.
        if (ecnt == 0 || ((ecnt + 1) % (SD*ND)) == 0) begin
            s_val   = value;
            s_dp    = dp;
            s_blink = blink_mask;
            s_dec   = dec_mode;
            s_lz    = lz_suppress;
        end
        @(posedge clk);
        #1;
        ecnt++;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("seg_dp", 32'(seg_dp), 32'(e_dp));
        chk("digit_idx", 32'(digit_idx), (ecnt / SD) % ND);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(seg_dp), 32'h1);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        value       = 16'h12AF;
        dec_mode    = 1'b0;
        lz_suppress = 1'b0;
        blink_mask  = '0;
        dp          = '0;
        model_clear();
        do_reset();

        run(20);

        dp = 4'b0101;
        run(36);
        dec_mode = 1'b1;
        run(40);

        dec_mode    = 1'b0;
        dp          = '0;
        value       = 16'h0050;
        lz_suppress = 1'b1;
        run(36);
        value = 16'h0000;
        dp    = 4'b1000;
        run(36);

        lz_suppress = 1'b0;
        dp          = '0;
        value       = 16'h1111;
        run(20);
        for (int unsigned k = 0; k < 16 && ((ecnt / SD) % ND) != 2; k++) step();
        step();
        value = 16'h2222;
        run(36);

        value      = 16'h1234;
        blink_mask = 4'b0001;
        run(100);

        step();
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(12);

        run(5);
        do_reset();
        run(40);

        for (int unsigned k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) value = 16'($urandom);
            if ($urandom_range(0, 9) == 0) value = 16'($urandom_range(0, 15)) << (4*$urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) dec_mode = 1'($urandom);
            if ($urandom_range(0, 19) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 14) == 0) en = ~en;
            if (k == 300) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
